// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle for fetch_queue: write side from instruction
// memory, read side toward decode, plus the redirect flush and the occupancy.
interface fetch_queue_if #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 11,
    parameter int INST_W = 32
);
    logic                     in_valid;
    logic [PC_W-1:0]          in_pc;
    logic [INST_W-1:0]        in_inst;
    logic                     in_ready;
    logic                     out_valid;
    logic [PC_W-1:0]          out_pc;
    logic [INST_W-1:0]        out_inst;
    logic                     out_ready;
    logic                     flush;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output in_valid, in_pc, in_inst, out_ready, flush,
        input  in_ready, out_valid, out_pc, out_inst, count
    );

    modport slave (
        input  in_valid, in_pc, in_inst, out_ready, flush,
        output in_ready, out_valid, out_pc, out_inst, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Fall-through instruction FIFO between instruction memory and decode, with
// flush shadow. Optional statistics outputs enabled by FETCH_QUEUE_STATS_EN.
module fetch_queue #(
    parameter int DEPTH        = 4,
    parameter int PC_W         = 11,
    parameter int INST_W       = 32,
    parameter int FLUSH_SHADOW = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    fetch_queue_if.slave           bus
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [$clog2(DEPTH):0] stat_hwm,
    output logic [15:0]            stat_flushed
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [1:0]    SHADOW_LD = 2'(FLUSH_SHADOW);

    typedef enum logic {NORMAL, SHADOW} state_t;

    state_t            state;
    logic [1:0]        shadow;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic [PC_W-1:0]   head_pc;
    logic [INST_W-1:0] head_inst;

    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    logic              push;
    logic              pop;
    logic              drop;
    logic [PW-1:0]     wr_nx;
    logic [PW-1:0]     rd_nx;
    logic [CW-1:0]     cnt_nx;
    logic [1:0]        shadow_nx;
    logic [PC_W-1:0]   head_pc_nx;
    logic [INST_W-1:0] head_inst_nx;

    assign bus.in_ready  = (cnt != FULL) || (state == SHADOW);
    assign bus.out_valid = (cnt != '0);
    assign bus.out_pc    = head_pc;
    assign bus.out_inst  = head_inst;
    assign bus.count     = cnt;

    always_comb begin
        push         = bus.in_valid && (cnt != FULL) && (state == NORMAL) && !bus.flush;
        pop          = (cnt != '0) && bus.out_ready && !bus.flush;
        drop         = bus.in_valid && (state == SHADOW) && !bus.flush;
        wr_nx        = wr_ptr;
        rd_nx        = rd_ptr;
        cnt_nx       = cnt;
        shadow_nx    = shadow;
        head_pc_nx   = head_pc;
        head_inst_nx = head_inst;
        if (bus.flush) begin
            wr_nx     = '0;
            rd_nx     = '0;
            cnt_nx    = '0;
            shadow_nx = SHADOW_LD;
        end else begin
            if (push) wr_nx = wr_ptr + PW'(1);
            if (pop)  rd_nx = rd_ptr + PW'(1);
            if (push && !pop)      cnt_nx = cnt + CW'(1);
            else if (pop && !push) cnt_nx = cnt - CW'(1);
            if (drop) shadow_nx = shadow - 2'd1;
        end
        // The head register is preloaded so the new head is visible right after the edge;
        // it bypasses storage when the entry being written this cycle becomes the head.
        if (cnt_nx != '0) begin
            if (push && (rd_nx == wr_ptr)) begin
                head_pc_nx   = bus.in_pc;
                head_inst_nx = bus.in_inst;
            end else begin
                head_pc_nx   = pc_mem[rd_nx];
                head_inst_nx = inst_mem[rd_nx];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= NORMAL;
            shadow    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            head_pc   <= '0;
            head_inst <= '0;
        end else begin
            state     <= (shadow_nx != '0) ? SHADOW : NORMAL;
            shadow    <= shadow_nx;
            wr_ptr    <= wr_nx;
            rd_ptr    <= rd_nx;
            cnt       <= cnt_nx;
            head_pc   <= head_pc_nx;
            head_inst <= head_inst_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= bus.in_pc;
            inst_mem[wr_ptr] <= bus.in_inst;
        end
    end

`ifdef FETCH_QUEUE_STATS_EN
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [CW-1:0] b);
        logic [16:0] sum;
        sum = 17'(a) + 17'(b);
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    logic [CW-1:0] flush_inc;

    always_comb begin
        flush_inc = '0;
        if (bus.flush)  flush_inc = cnt;
        else if (drop)  flush_inc = CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_hwm     <= '0;
            stat_flushed <= '0;
        end else begin
            if (cnt_nx > stat_hwm) stat_hwm <= cnt_nx;
            stat_flushed <= sat_add16(stat_flushed, flush_inc);
        end
    end
`endif
endmodule
